// File: rtl/key_note_scheduler.sv
// Round-robin note scheduler for an 8-key instrument: grants one requesting key at a time,
// plays it for NOTE_CYCLES cycles, then holds a GAP_CYCLES silence before the next grant.
module key_note_scheduler #(
    parameter int NOTE_CYCLES = 16,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] key_req,
    output logic [7:0] grant,
    output logic [2:0] note_idx,
    output logic       note_valid,
    output logic       busy
);

    localparam int MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    last_q, last_d;

    logic          pick_valid;
    logic [2:0]    pick_idx;

    // Search upward from the key after the last grant, wrapping 7 -> 0; 3-bit add wraps for free.
    always_comb begin
        logic [2:0] cand;
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        pick_valid = 1'b0;
        pick_idx   = last_q;
        cand       = last_q;
        for (int k = 1; k < 9; k++) begin
            cand = last_q + 3'(k);
            if (!pick_valid && key_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (enable && pick_valid) begin
                    state_d = PLAY;
                    cnt_d   = NOTE_LOAD;
                    idx_d   = pick_idx;
                    last_d  = pick_idx;
                end
            end
            PLAY: begin
                // Counter holds cycles remaining including the current one.
                if (cnt_q == CNT_ONE) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            last_q  <= 3'd7;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign note_valid = (state_q == PLAY);
    assign grant      = note_valid ? (8'd1 << idx_q) : 8'd0;
    assign note_idx   = idx_q;
    assign busy       = (state_q == PLAY) || (state_q == GAP);

endmodule
